// File: rtl/lab_io_pkg.sv
// lab_io_pkg: shared types and constants for the board I/O path.
package lab_io_pkg;
   typedef enum logic [1:0] {RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE} btn_state_t;
   localparam int BTN_STABLE_1MS = 50000;
endpackage

// File: rtl/button_debounce_sync2_r.sv
// sync2_r: two-flop synchronizer with synchronous reset to INIT.
module sync2_r #(
   parameter bit INIT = 1'b0
) (
   input  logic Clk,
   input  logic Reset,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge Clk) begin
      if (Reset) {q, m} <= {INIT, INIT};
      else {q, m} <= {m, d};
   end
endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronized, counter-debounced button with press/release strobes.
// Defining BUTTON_REPEAT_EN adds auto-repeat press strobes while held.
import lab_io_pkg::*;
module button_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int REPEAT_DELAY  = 16,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic d,
   output logic level,
   output logic press,
   output logic rel
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad
      $error("button_debounce: illegal parameter value");
   end
   logic q, s, at_lim, rep_fire;
   logic level_n, press_n, rel_n;
   logic [CW-1:0] cnt, cnt_n;
   btn_state_t state, state_n;
   sync2_r #(.INIT(ACTIVE_LOW)) u_sync (.Clk(Clk), .Reset(Reset), .d(d), .q(q));
   assign s = q ^ ACTIVE_LOW;
   assign at_lim = cnt == CW'(STABLE_CYCLES - 1);
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      level_n = level;
      press_n = 1'b0;
      rel_n   = 1'b0;
      case (state)
         RELEASED: if (s) begin state_n = CHECK_PRESS; cnt_n = CW'(1); end
         CHECK_PRESS:
            if (!s) begin state_n = RELEASED; cnt_n = '0; end
            else if (at_lim) begin state_n = PRESSED; cnt_n = '0; level_n = 1'b1; press_n = 1'b1; end
            else cnt_n = cnt + 1'b1;
         PRESSED: if (!s) begin state_n = CHECK_RELEASE; cnt_n = CW'(1); end
         CHECK_RELEASE:
            if (s) begin state_n = PRESSED; cnt_n = '0; end
            else if (at_lim) begin state_n = RELEASED; cnt_n = '0; level_n = 1'b0; rel_n = 1'b1; end
            else cnt_n = cnt + 1'b1;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= RELEASED;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         level <= level_n;
         press <= press_n | rep_fire;
         rel   <= rel_n;
      end
   end
`ifdef BUTTON_REPEAT_EN
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
   logic [RW-1:0] rep, rep_n;
   // Down-counter, reloaded with the initial delay whenever not steadily held.
   always_comb begin
      rep_n    = RW'(REPEAT_DELAY - 1);
      rep_fire = 1'b0;
      if (state == PRESSED && s) begin
         rep_fire = rep == '0;
         rep_n    = rep_fire ? RW'(REPEAT_PERIOD - 1) : rep - 1'b1;
      end
   end
   always_ff @(posedge Clk) rep <= Reset ? RW'(REPEAT_DELAY - 1) : rep_n;
`else
   assign rep_fire = 1'b0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed and random stimulus against a run-length reference model.
module tb_button_debounce;
   localparam int N = 4;
   localparam int RD = 8;
   localparam int RP = 3;
`ifdef BUTTON_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif
   logic Clk = 1'b0, Reset = 1'b1, d = 1'b1, d_n;
   logic level, press, rel, level2, press2, rel2;
   int total = 0, bad = 0;
   logic m_level = 1'b0, ep = 1'b0, er = 1'b0, h1 = 1'b1, h2 = 1'b1;
   int m_run = 0, m_held = 0, presses = 0;
   assign d_n = ~d;
   always #5 Clk = ~Clk;
   button_debounce #(.STABLE_CYCLES(N), .ACTIVE_LOW(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .Clk(Clk), .Reset(Reset), .d(d), .level(level), .press(press), .rel(rel));
   button_debounce #(.STABLE_CYCLES(N), .ACTIVE_LOW(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut2 (
      .Clk(Clk), .Reset(Reset), .d(d_n), .level(level2), .press(press2), .rel(rel2));

   task automatic chk(input string tag, input logic got, input logic want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s t=%0t got %b want %b", tag, $time, got, want);
      end
   endtask

   // One clock: a level change is accepted after N consecutive disagreeing samples.
   task automatic step(input logic dv, input logic rv);
      logic s;
      d = dv;
      Reset = rv;
      @(posedge Clk);
      s = ~h2;
      h2 = h1;
      h1 = dv;
      ep = 1'b0;
      er = 1'b0;
      if (rv) begin
         m_level = 1'b0; m_run = 0; m_held = 0; h1 = 1'b1; h2 = 1'b1;
      end else if (s != m_level) begin
         m_run++;
         if (m_run == N) begin
            m_level = s; m_run = 0; m_held = 0; ep = s; er = ~s;
         end
      end else begin
         if (m_level && m_run == 0) begin
            m_held++;
            ep = REP_EN && (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0));
         end else m_held = 0;
         m_run = 0;
      end
      #1;
      chk("level", level, m_level);
      chk("press", press, ep);
      chk("release", rel, er);
      chk("overlap", press & rel, 1'b0);
      chk("pol_level", level2, level);
      chk("pol_press", press2, press);
      chk("pol_release", rel2, rel);
      if (press) presses++;
   endtask

   task automatic run(input logic dv, input int n);
      for (int i = 0; i < n; i++) step(dv, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      run(1'b1, 20);
      presses = 0;
      run(1'b0, 20);
      chk("one_press", presses == (REP_EN ? 4 : 1), 1'b1);
      run(1'b1, 3);
      run(1'b0, 2);
      run(1'b1, 10);
      chk("released", level, 1'b0);
      presses = 0;
      run(1'b0, 1); run(1'b1, 1);
      run(1'b0, 2); run(1'b1, 1);
      run(1'b0, 3); run(1'b1, 1);
      chk("no_bounce_press", presses == 0, 1'b1);
      run(1'b0, 10);
      chk("held_press", level, 1'b1);
      run(1'b1, 12);
      run(1'b0, 4);
      step(1'b0, 1'b1);
      run(1'b0, 10);
      step(1'b0, 1'b1);
      run(1'b0, 30);
      run(1'b1, 3);
      run(1'b0, 12);
      run(1'b1, 12);
      for (int k = 0; k < 400; k++) begin
         int len = $urandom_range(1, 12);
         logic v = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) step(v, 1'b1);
         run(v, len);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
